// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with condition-flag derivation and the architectural flags register.
// Define EX_MEM_FLAG_BYPASS_EN to expose next-cycle flags combinationally on the flags output.
module ex_mem_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_co,
  input  logic                alu_ci_msb,
  input  logic [2:0]          alu_sel,
  input  logic                set_flags,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [WIDTH-1:0]    ex_store_data,
  input  logic                stall,
  input  logic                flush,
  output logic                mem_valid,
  output logic [WIDTH-1:0]    mem_alu_result,
  output logic [WIDTH-1:0]    mem_store_data,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic [3:0]          flags
);

  logic                valid_d, valid_q;
  logic [WIDTH-1:0]    result_d, result_q;
  logic [WIDTH-1:0]    store_d, store_q;
  logic [REG_BITS-1:0] rd_d, rd_q;
  logic                reg_write_d, reg_write_q;
  logic                mem_read_d, mem_read_q;
  logic                mem_write_d, mem_write_q;
  logic [3:0]          flags_d, flags_q;

  logic [3:0] flags_new;
  logic       arith_sel, legal_sel, flag_en;

  // Flags are {N, Z, C, V}; C/V only carry meaning for add/sub.
  always_comb begin
    arith_sel    = (alu_sel == 3'b010) || (alu_sel == 3'b011);
    legal_sel    = (alu_sel != 3'b001) && (alu_sel != 3'b111);
    flags_new[3] = alu_result[WIDTH-1];
    flags_new[2] = (alu_result == '0);
    flags_new[1] = arith_sel & alu_co;
    flags_new[0] = arith_sel & (alu_co ^ alu_ci_msb);
    flag_en      = ex_valid & set_flags & ~stall & ~flush & legal_sel;
    flags_d      = flag_en ? flags_new : flags_q;
  end

  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    store_d     = store_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (!stall) begin
      if (flush) begin
        valid_d     = 1'b0;
        result_d    = '0;
        store_d     = '0;
        rd_d        = '0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end else begin
        // Data fields load even for a non-valid slot; only controls are masked.
        valid_d     = ex_valid;
        result_d    = alu_result;
        store_d     = ex_store_data;
        rd_d        = ex_rd;
        reg_write_d = ex_valid & ex_reg_write;
        mem_read_d  = ex_valid & ex_mem_read;
        mem_write_d = ex_valid & ex_mem_write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      flags_q     <= flags_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;

`ifdef EX_MEM_FLAG_BYPASS_EN
  // Lets a branch right behind a flag setter resolve without a bubble.
  assign flags = flags_d;
`else
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table followed by randomized traffic vs. a reference model.
module tb_ex_mem_stage;
  localparam int W = 64;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         reset, ex_valid, alu_co, alu_ci_msb, set_flags;
  logic [W-1:0] alu_result, ex_store_data;
  logic [2:0]   alu_sel;
  logic [R-1:0] ex_rd;
  logic         ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
  logic         mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [W-1:0] mem_alu_result, mem_store_data;
  logic [R-1:0] mem_rd;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  ex_mem_stage #(.WIDTH(W), .REG_BITS(R)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
    .alu_co(alu_co), .alu_ci_msb(alu_ci_msb), .alu_sel(alu_sel), .set_flags(set_flags),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .flags(flags)
  );

  typedef struct {
    logic         rst_n, ev, co, ci, sf, rw, st, fl;
    logic [W-1:0] res;
    logic [2:0]   sel;
    logic [R-1:0] rd;
    logic         e_valid, e_rw;
    logic [W-1:0] e_res;
    logic [R-1:0] e_rd;
    logic [3:0]   e_flags;
  } vec_t;

  typedef struct {
    logic         valid, rw, mr, mw;
    logic [W-1:0] res, sd;
    logic [R-1:0] rd;
    logic [3:0]   flags;
  } st_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic rst_n, ev, input logic [W-1:0] res, input logic co, ci,
                              input logic [2:0] sel, input logic sf, input logic [R-1:0] rd,
                              input logic rw, st, fl, e_valid, input logic [W-1:0] e_res,
                              input logic [R-1:0] e_rd, input logic e_rw, input logic [3:0] e_flags);
    vec_t v;
    v.rst_n = rst_n; v.ev = ev; v.res = res; v.co = co; v.ci = ci; v.sel = sel; v.sf = sf;
    v.rd = rd; v.rw = rw; v.st = st; v.fl = fl;
    v.e_valid = e_valid; v.e_res = e_res; v.e_rd = e_rd; v.e_rw = e_rw; v.e_flags = e_flags;
    return v;
  endfunction

  task automatic drive(input logic rst_n, ev, input logic [W-1:0] res, input logic co, ci,
                       input logic [2:0] sel, input logic sf, input logic [R-1:0] rd,
                       input logic rw, mr, mw, input logic [W-1:0] sd, input logic st, fl);
    reset = rst_n; ex_valid = ev; alu_result = res; alu_co = co; alu_ci_msb = ci;
    alu_sel = sel; set_flags = sf; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_store_data = sd; stall = st; flush = fl;
  endtask

  // Reference: flags from the architectural definition of N/Z/C/V.
  function automatic logic [3:0] derive(input logic [W-1:0] res, input logic co, ci,
                                        input logic [2:0] sel);
    logic is_addsub;
    is_addsub = (sel == 3'd2) || (sel == 3'd3);
    return {($signed(res) < 0), (res == 0), is_addsub && co, is_addsub && (co != ci)};
  endfunction

  localparam logic [W-1:0] MSB = 64'h8000_0000_0000_0000;
  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    st_t m, nx;
    logic [3:0] nf;
    logic       en, legal;
    logic       r_rst, r_ev, r_co, r_ci, r_sf, r_rw, r_mr, r_mw, r_st, r_fl;
    logic [W-1:0] r_res, r_sd;
    logic [2:0] r_sel;
    logic [R-1:0] r_rd;

    //              rst ev res        co ci sel     sf rd rw st fl | valid res      rd rw flags
    tbl[0]  = mk(0, 1, 64'hFF,    1, 0, 3'b010, 1, 9, 1, 0, 0,   0, 64'h0,  0, 0, 4'b0000);
    tbl[1]  = mk(0, 1, MSB,       1, 1, 3'b011, 1, 3, 1, 1, 1,   0, 64'h0,  0, 0, 4'b0000);
    tbl[2]  = mk(1, 1, 64'h5,     0, 0, 3'b100, 0, 3, 1, 0, 0,   1, 64'h5,  3, 1, 4'b0000);
    tbl[3]  = mk(1, 1, 64'h0,     1, 1, 3'b011, 1, 1, 1, 0, 0,   1, 64'h0,  1, 1, 4'b0110);
    tbl[4]  = mk(1, 1, MSB,       0, 1, 3'b010, 1, 2, 1, 0, 0,   1, MSB,    2, 1, 4'b1001);
    tbl[5]  = mk(1, 1, 64'h0,     1, 0, 3'b100, 1, 2, 1, 0, 0,   1, 64'h0,  2, 1, 4'b0100);
    tbl[6]  = mk(1, 1, 64'h77,    0, 0, 3'b010, 0, 7, 1, 0, 0,   1, 64'h77, 7, 1, 4'b0100);
    tbl[7]  = mk(1, 1, MSB,       1, 0, 3'b010, 1, 9, 0, 1, 1,   1, 64'h77, 7, 1, 4'b0100);
    tbl[8]  = mk(1, 0, 64'h1,     0, 1, 3'b011, 1, 8, 1, 1, 1,   1, 64'h77, 7, 1, 4'b0100);
    tbl[9]  = mk(1, 1, 64'h0,     1, 1, 3'b011, 1, 9, 1, 1, 1,   1, 64'h77, 7, 1, 4'b0100);
    tbl[10] = mk(1, 1, 64'h0,     1, 0, 3'b011, 1, 9, 1, 0, 1,   0, 64'h0,  0, 0, 4'b0100);
    tbl[11] = mk(1, 1, MSB,       1, 0, 3'b011, 0, 4, 1, 0, 0,   1, MSB,    4, 1, 4'b0100);
    tbl[12] = mk(1, 0, MSB,       0, 1, 3'b010, 1, 5, 1, 0, 0,   0, MSB,    5, 0, 4'b0100);
    tbl[13] = mk(1, 1, MSB,       1, 0, 3'b111, 1, 6, 1, 0, 0,   1, MSB,    6, 1, 4'b0100);
    tbl[14] = mk(1, 1, MSB,       0, 1, 3'b001, 1, 6, 1, 0, 0,   1, MSB,    6, 1, 4'b0100);
    tbl[15] = mk(0, 1, 64'h9,     1, 0, 3'b010, 1, 3, 1, 1, 1,   0, 64'h0,  0, 0, 4'b0000);
    tbl[16] = mk(1, 1, 64'h5,     1, 0, 3'b010, 1, 1, 1, 0, 0,   1, 64'h5,  1, 1, 4'b0011);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst_n, tbl[i].ev, tbl[i].res, tbl[i].co, tbl[i].ci, tbl[i].sel, tbl[i].sf,
            tbl[i].rd, tbl[i].rw, 1'b0, 1'b0, '0, tbl[i].st, tbl[i].fl);
      #1;
      if (i > 0 && tbl[i].rst_n) begin
`ifdef EX_MEM_FLAG_BYPASS_EN
        chk($sformatf("v%0d pre_flags", i), {60'd0, flags}, {60'd0, tbl[i].e_flags});
`else
        chk($sformatf("v%0d pre_flags", i), {60'd0, flags}, {60'd0, tbl[i-1].e_flags});
`endif
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), {63'd0, mem_valid}, {63'd0, tbl[i].e_valid});
      chk($sformatf("v%0d result", i), mem_alu_result, tbl[i].e_res);
      chk($sformatf("v%0d rd", i), {59'd0, mem_rd}, {59'd0, tbl[i].e_rd});
      chk($sformatf("v%0d reg_write", i), {63'd0, mem_reg_write}, {63'd0, tbl[i].e_rw});
      chk($sformatf("v%0d flags", i), {60'd0, flags}, {60'd0, tbl[i].e_flags});
    end

    // Random traffic; first cycle is a reset so model and DUT start aligned.
    m = '{default: '0};
    for (int c = 0; c < 600; c++) begin
      r_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
      r_ev  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       r_res = '0;
        1:       r_res = {1'b1, 31'($urandom), 32'($urandom)};
        default: r_res = {32'($urandom), 32'($urandom)};
      endcase
      r_co = 1'($urandom); r_ci = 1'($urandom); r_sel = 3'($urandom);
      r_sf = ($urandom_range(0, 2) != 0); r_rd = R'($urandom);
      r_rw = 1'($urandom); r_mr = 1'($urandom); r_mw = 1'($urandom);
      r_sd = {32'($urandom), 32'($urandom)};
      r_st = ($urandom_range(0, 4) == 0); r_fl = ($urandom_range(0, 5) == 0);

      legal = !(r_sel inside {3'd1, 3'd7});
      nf    = derive(r_res, r_co, r_ci, r_sel);
      en    = r_ev && r_sf && !r_st && !r_fl && legal;
      nx    = m;
      if (!r_rst) nx = '{default: '0};
      else if (r_st) nx = m;
      else if (r_fl) begin
        nx = '{default: '0};
        nx.flags = m.flags;
      end else begin
        nx.valid = r_ev; nx.res = r_res; nx.sd = r_sd; nx.rd = r_rd;
        nx.rw = r_ev && r_rw; nx.mr = r_ev && r_mr; nx.mw = r_ev && r_mw;
        nx.flags = en ? nf : m.flags;
      end

      drive(r_rst, r_ev, r_res, r_co, r_ci, r_sel, r_sf, r_rd, r_rw, r_mr, r_mw, r_sd, r_st, r_fl);
      #1;
      if (c > 0 && r_rst) begin
`ifdef EX_MEM_FLAG_BYPASS_EN
        chk($sformatf("r%0d pre_flags", c), {60'd0, flags}, {60'd0, nx.flags});
`else
        chk($sformatf("r%0d pre_flags", c), {60'd0, flags}, {60'd0, m.flags});
`endif
      end
      @(posedge clk); #1;
      m = nx;
      chk($sformatf("r%0d valid", c), {63'd0, mem_valid}, {63'd0, m.valid});
      chk($sformatf("r%0d result", c), mem_alu_result, m.res);
      chk($sformatf("r%0d store", c), mem_store_data, m.sd);
      chk($sformatf("r%0d rd", c), {59'd0, mem_rd}, {59'd0, m.rd});
      chk($sformatf("r%0d ctrl", c), {61'd0, mem_reg_write, mem_mem_read, mem_mem_write},
          {61'd0, m.rw, m.mr, m.mw});
      chk($sformatf("r%0d flags", c), {60'd0, flags}, {60'd0, m.flags});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
